// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MISS  = 2'd2
    } state_t;

    localparam logic [15:0] NOP_INSTR    = 16'h0000;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
endpackage

// File: rtl/if_miss_counter.sv
// Saturating 16-bit event counter, cleared only by reset.
module if_miss_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= 16'h0000;
        else if (inc && count != 16'hFFFF)
            count <= count + 16'd1;
    end
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC sequencing, icache request, registered output to ID.
// Define IF_MISS_CNT_EN to build the icache miss counter behind miss_count.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode,
    input  logic        stall,
    input  logic        jump,
    input  logic [15:0] jump_target,
    input  logic        i_hit,
    input  logic [15:0] ic_instr,
    output logic        ic_req,
    output logic [15:0] ic_addr,
    output logic [15:0] instr_o,
    output logic        instr_valid,
    output logic [15:0] pc_o,
    output logic [15:0] pc_plus1,
    output logic [15:0] miss_count
);
    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [15:0] instr_n, pc_o_n;
    logic        valid_n;

    // Request is a pure decode of the state so reset drops it without a clock edge.
    assign ic_req   = (state != IDLE);
    assign ic_addr  = pc;
    assign pc_plus1 = pc_o + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            pc_o        <= RESET_PC;
            instr_o     <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pc_o        <= pc_o_n;
            instr_o     <= instr_n;
            instr_valid <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        pc_o_n  = pc_o;
        instr_n = instr_o;
        valid_n = instr_valid;
        if (!mode) begin
            state_n = IDLE;
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
        end else if (jump) begin
            // Any hit this cycle belongs to the abandoned path and is dropped.
            state_n = FETCH;
            pc_n    = jump_target;
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    state_n = FETCH;
                    instr_n = NOP_INSTR;
                    valid_n = 1'b0;
                end
                FETCH, MISS: begin
                    if (i_hit) begin
                        state_n = FETCH;
                        instr_n = ic_instr;
                        valid_n = 1'b1;
                        pc_o_n  = pc;
                        pc_n    = pc + 16'd1;
                    end else begin
                        state_n = MISS;
                        instr_n = NOP_INSTR;
                        valid_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef IF_MISS_CNT_EN
    logic miss_inc;

    // Count entries into MISS only, not every cycle spent waiting there.
    assign miss_inc = (state == FETCH) && mode && !jump && !stall && !i_hit;

    if_miss_counter u_miss_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_inc),
        .count (miss_count)
    );
`else
    assign miss_count = 16'h0000;
`endif
endmodule

// File: tb/tb_if_fetch.sv
// Directed scoreboard bench for if_fetch; expected fetches are queued when the hit is driven.
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0, stall = 1'b0, jump = 1'b0, i_hit = 1'b0;
    logic [15:0] jump_target = 16'h0000, ic_instr = 16'h0000;
    logic        ic_req, instr_valid;
    logic [15:0] ic_addr, instr_o, pc_o, pc_plus1, miss_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_exp = 32'h0;
    logic [15:0] exp_miss;

    if_fetch #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .stall       (stall),
        .jump        (jump),
        .jump_target (jump_target),
        .i_hit       (i_hit),
        .ic_instr    (ic_instr),
        .ic_req      (ic_req),
        .ic_addr     (ic_addr),
        .instr_o     (instr_o),
        .instr_valid (instr_valid),
        .pc_o        (pc_o),
        .pc_plus1    (pc_plus1),
        .miss_count  (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dat(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // sbk: 0 = nothing fetched, 1 = hit accepted at exp_addr, 2 = output held from before
    task automatic cyc(input logic m, input logic st, input logic j, input logic [15:0] jt,
                       input logic h, input logic [15:0] data, input logic exp_req,
                       input logic [15:0] exp_addr, input int sbk);
        logic [31:0] e;
        mode = m; stall = st; jump = j; jump_target = jt; i_hit = h; ic_instr = data;
        #1;
        chk("ic_req", {15'h0, ic_req}, {15'h0, exp_req});
        if (exp_req) chk("ic_addr", ic_addr, exp_addr);
        if (sbk == 1) begin
            last_exp = {exp_addr, data};
            sb_q.push_back(last_exp);
        end else if (sbk == 2) begin
            sb_q.push_back(last_exp);
        end
        @(posedge clk); #1;
        chk("instr_valid", {15'h0, instr_valid}, {15'h0, (sbk != 0)});
        if (sbk != 0) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 16'h0001, 16'h0000);
            end else begin
                e = sb_q.pop_front();
                chk("pc_o", pc_o, e[31:16]);
                chk("instr_o", instr_o, e[15:0]);
            end
        end else begin
            chk("instr_o_nop", instr_o, 16'h0000);
        end
        @(negedge clk);
    endtask

    initial begin
`ifdef IF_MISS_CNT_EN
        exp_miss = 16'h0001;
`else
        exp_miss = 16'h0000;
`endif
        #1;
        chk("rst_ic_req", {15'h0, ic_req}, 16'h0000);
        chk("rst_instr", instr_o, 16'h0000);
        chk("rst_valid", {15'h0, instr_valid}, 16'h0000);
        chk("rst_pc_o", pc_o, 16'h0000);
        chk("rst_miss", miss_count, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        cyc(0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0);
        cyc(1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0);
        // Straight-line hits with instruction == address
        for (int a = 0; a < 5; a++)
            cyc(1, 0, 0, 16'h0, 1, 16'(a), 1, 16'(a), 1);
        // Three miss cycles at 0x0005, then the hit
        for (int k = 0; k < 3; k++)
            cyc(1, 0, 0, 16'h0, 0, 16'hDEAD, 1, 16'h0005, 0);
        cyc(1, 0, 0, 16'h0, 1, dat(16'h0005), 1, 16'h0005, 1);
        chk("pc_plus1_6", pc_plus1, 16'h0006);
        chk("miss_count", miss_count, exp_miss);
        // Stall discards a hit and holds the output
        cyc(1, 1, 0, 16'h0, 1, dat(16'h0006), 1, 16'h0006, 2);
        cyc(1, 0, 0, 16'h0, 1, dat(16'h0006), 1, 16'h0006, 1);
        // Jump during MISS with a same-cycle hit for the old address
        cyc(1, 0, 0, 16'h0, 0, 16'h0, 1, 16'h0007, 0);
        cyc(1, 0, 1, 16'h0100, 1, dat(16'h0007), 1, 16'h0007, 0);
        cyc(1, 0, 0, 16'h0, 1, dat(16'h0100), 1, 16'h0100, 1);
        // Jump wins over a simultaneous stall
        cyc(1, 1, 1, 16'hFFFE, 1, dat(16'h0101), 1, 16'h0101, 0);
        cyc(1, 0, 0, 16'h0, 1, dat(16'hFFFE), 1, 16'hFFFE, 1);
        cyc(1, 0, 0, 16'h0, 1, dat(16'hFFFF), 1, 16'hFFFF, 1);
        chk("pc_plus1_wrap", pc_plus1, 16'h0000);
        cyc(1, 0, 0, 16'h0, 1, dat(16'h0000), 1, 16'h0000, 1);
        // Halt: hit ignored, request dropped, PC held across IDLE
        cyc(0, 0, 0, 16'h0, 1, dat(16'h0001), 1, 16'h0001, 0);
        cyc(0, 0, 0, 16'h0, 1, dat(16'h0001), 0, 16'h0001, 0);
        cyc(1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0001, 0);
        cyc(1, 0, 0, 16'h0, 1, dat(16'h0001), 1, 16'h0001, 1);
        // Reset while in MISS acts without a clock edge
        cyc(1, 0, 0, 16'h0, 0, 16'h0, 1, 16'h0002, 0);
        chk("in_miss_req", {15'h0, ic_req}, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("amid_ic_req", {15'h0, ic_req}, 16'h0000);
        chk("amid_instr", instr_o, 16'h0000);
        chk("amid_pc_o", pc_o, 16'h0000);
        chk("amid_miss", miss_count, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0000, 0);
        cyc(1, 0, 0, 16'h0, 1, dat(16'h0000), 1, 16'h0000, 1);

        chk("sb_empty", 16'(sb_q.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
